// File: rtl/addsub_sequencer.sv
// Sequencer for a shared W-bit adder/subtractor: single-cycle ADD/SUB and
// unsigned MUL by repeated addition, with valid/ready on both sides.
//
// state | meaning
// IDLE  | ready for a new request, adder operands parked at 0
// EXEC  | one ADD/SUB pass through the adder
// MUL   | one accumulate pass per remaining count
// DONE  | result held on out_res/out_flag until consumed
module addsub_sequencer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         out_flag,
  output logic [W-1:0] as_a,
  output logic [W-1:0] as_b,
  output logic         as_ci,
  input  logic [W-1:0] as_s,
  input  logic         as_co
);

  localparam logic [1:0]   OP_SUB = 2'b01;
  localparam logic [1:0]   OP_MUL = 2'b10;
  localparam logic [W-1:0] ONE    = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t       state;
  logic [1:0]   op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] acc;
  logic [W-1:0] cnt;
  logic         ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= in_op;
            a_q  <= in_a;
            b_q  <= in_b;
            if (in_op == OP_MUL) begin
              acc <= '0;
              cnt <= in_b;
              ovf <= 1'b0;
              if (in_b == '0) begin
                out_res   <= '0;
                out_flag  <= 1'b0;
                out_valid <= 1'b1;
                state     <= DONE;
              end else begin
                state <= MUL;
              end
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          out_res   <= as_s;
          // subtraction reports borrow, which is the inverse of the adder carry
          out_flag  <= (op_q == OP_SUB) ? ~as_co : as_co;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        MUL: begin
          acc <= as_s;
          ovf <= ovf | as_co;
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            out_res   <= as_s;
            out_flag  <= ovf | as_co;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);

  always_comb begin
    as_a  = '0;
    as_b  = '0;
    as_ci = 1'b0;
    case (state)
      EXEC: begin
        as_a  = a_q;
        as_b  = b_q;
        as_ci = (op_q == OP_SUB);
      end
      MUL: begin
        as_a = acc;
        as_b = a_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_addsub_sequencer.sv
// Bench for addsub_sequencer: behavioural adder, arithmetic result model,
// per-cycle compare, plus directed vectors with literal expectations.
module tb_addsub_sequencer;
  localparam int W = 3;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_op = 2'b00;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_res;
  logic         out_flag;
  logic [W-1:0] as_a;
  logic [W-1:0] as_b;
  logic         as_ci;
  logic [W-1:0] as_s;
  logic         as_co;
  logic [W:0]   sum;

  addsub_sequencer #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_flag(out_flag),
    .as_a(as_a), .as_b(as_b), .as_ci(as_ci), .as_s(as_s), .as_co(as_co)
  );

  // shared adder: Ci=1 inverts B, giving A-B
  assign sum   = {1'b0, as_a} + {1'b0, (as_ci ? ~as_b : as_b)} + {{W{1'b0}}, as_ci};
  assign as_s  = sum[W-1:0];
  assign as_co = sum[W];

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_op(input int op, input int a, input int b,
                          output int res, output int flag, output int lat);
    case (op)
      1: begin res = (a - b + M) % M; flag = (a < b);      lat = 2;     end
      2: begin res = (a * b) % M;     flag = (a * b >= M); lat = b + 1; end
      default: begin res = (a + b) % M; flag = (a + b >= M); lat = 2; end
    endcase
  endtask

  // model state: one outstanding operation from accept to result handshake
  int cyc = 0;
  bit busy = 0;
  int ac = 0, lat = 0, j = 0;
  int m_op = 0, m_a = 0, m_b = 0, m_res = 0, m_flag = 0;
  bit ev;
  int got_res[$];
  int got_flag[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0;
    end else begin
      cyc++;
      j  = cyc - ac;
      ev = busy && (j >= lat);
      check("out_valid", out_valid, ev);
      check("in_ready", in_ready, !busy);
      if (ev) begin
        check("out_res", out_res, m_res);
        check("out_flag", out_flag, m_flag);
      end
      if (busy && !ev) begin
        if (m_op == 2) begin
          check("mul_as_a", as_a, (m_a * (j - 1)) % M);
          check("mul_as_b", as_b, m_a);
          check("mul_as_ci", as_ci, 0);
        end else begin
          check("exec_as_a", as_a, m_a);
          check("exec_as_b", as_b, m_b);
          check("exec_as_ci", as_ci, (m_op == 1));
        end
      end else begin
        check("idle_as_a", as_a, 0);
        check("idle_as_b", as_b, 0);
        check("idle_as_ci", as_ci, 0);
      end
      if (ev && out_ready) begin
        got_res.push_back(out_res);
        got_flag.push_back(out_flag);
        busy = 0;
      end else if (!busy && in_valid) begin
        busy = 1;
        ac   = cyc;
        m_op = in_op; m_a = in_a; m_b = in_b;
        model_op(m_op, m_a, m_b, m_res, m_flag, lat);
      end
    end
  end

  task automatic issue(input int op, input int a, input int b);
    int n;
    @(posedge clk); #1;
    in_op = op[1:0]; in_a = a[W-1:0]; in_b = b[W-1:0]; in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 60);
    if (!out_valid) check("result_timeout", 0, 1);
  endtask

  task automatic release_out();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input int op, input int a, input int b,
                        input int eres, input int eflag, input int elat);
    int n;
    issue(op, a, b);
    wait_out(n);
    check({name, "_lat"}, n, elat);
    check({name, "_res"}, out_res, eres);
    check({name, "_flag"}, out_flag, eflag);
    release_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res", out_res, 0);
    check("rst_out_flag", out_flag, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_as_a", as_a, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_op("add_3_2", 0, 3, 2, 5, 0, 2);

    issue(1, 2, 5);
    check("sub_as_ci", as_ci, 1);
    wait_out(n);
    check("sub_2_5_lat", n, 2);
    check("sub_2_5_res", out_res, 5);
    check("sub_2_5_flag", out_flag, 1);
    release_out();
    run_op("sub_6_1", 1, 6, 1, 5, 0, 2);

    issue(2, 3, 2);
    check("mul_first_as_a", as_a, 0);
    check("mul_first_as_b", as_b, 3);
    wait_out(n);
    check("mul_3_2_lat", n, 3);
    check("mul_3_2_res", out_res, 6);
    check("mul_3_2_flag", out_flag, 0);
    release_out();
    run_op("mul_3_3", 2, 3, 3, 1, 1, 4);
    run_op("mul_5_0", 2, 5, 0, 0, 0, 1);
    run_op("rsv_3_6", 3, 3, 6, 1, 1, 2);
    run_op("add_7_7", 0, 7, 7, 6, 1, 2);

    // backpressure with a second request waiting
    issue(0, 1, 1);
    wait_out(n);
    check("bp_res", out_res, 2);
    @(posedge clk); #1;
    in_op = 2'b00; in_a = 3'd2; in_b = 3'd2; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_res", out_res, 2);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_in_ready", in_ready, 0);
    end
    release_out();
    @(negedge clk);
    check("bp_second_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out(n);
    check("bp_second_lat", n, 2);
    check("bp_second_res", out_res, 4);
    release_out();

    // reset in the third MUL cycle
    issue(2, 7, 7);
    repeat (2) begin @(posedge clk); #1; end
    check("rmul_as_a", as_a, 6);
    rst_n = 1'b0;
    #1;
    check("rmul_out_valid", out_valid, 0);
    check("rmul_out_res", out_res, 0);
    check("rmul_out_flag", out_flag, 0);
    check("rmul_as_a0", as_a, 0);
    check("rmul_as_b0", as_b, 0);
    check("rmul_as_ci0", as_ci, 0);
    check("rmul_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rmul_release_ready", in_ready, 1);
    run_op("post_rst_add", 0, 1, 2, 3, 0, 2);

    // back-to-back, out_ready and in_valid held high
    got_res.delete();
    got_flag.delete();
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_op = 2'b00; in_a = 3'd3; in_b = 3'd4; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ready && n < 50);
      if (!in_ready) check("b2b_accept_timeout", 0, 1);
      @(posedge clk); #1;
      if (i == 0) begin in_op = 2'b01; in_a = 3'd1; in_b = 3'd3; end
      else if (i == 1) begin in_op = 2'b10; in_a = 3'd2; in_b = 3'd5; end
      else in_valid = 1'b0;
    end
    n = 0;
    while (got_res.size() < 3 && n < 60) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    check("b2b_count", got_res.size(), 3);
    if (got_res.size() >= 3) begin
      check("b2b_add_res", got_res[0], 7);
      check("b2b_add_flag", got_flag[0], 0);
      check("b2b_sub_res", got_res[1], 6);
      check("b2b_sub_flag", got_flag[1], 1);
      check("b2b_mul_res", got_res[2], 2);
      check("b2b_mul_flag", got_flag[2], 1);
    end
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
